mask_window_ctrl: RTL and testbench
===================================

# mask_window_ctrl

Sequencer and two-port arbiter for the 512-bit mask generator in the connected-domain filter. It accepts window requests from two requesters under round-robin arbitration. For each request it drives the generator twice: a right-fill pass, then a left-fill pass. It combines the two masks with AND or OR and presents the 512-bit result on a valid/ready output with requester ID and a timeout error flag.

## Interface
- MASK_W, 512, mask width (fixed; generator width)
- IDX_W, 9, bound/count width
- TIMEOUT, 31, max cycles to wait for generator done per pass
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_req0_valid / i_req1_valid  in  1  request pending
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle (valid & ready)
- i_reqN_rcnt  in  9  ones filled from LSB side (right pass bound)
- i_reqN_lcnt  in  9  ones filled from MSB side (left pass bound)
- i_reqN_op  in  1  0 = AND (window), 1 = OR (edges)
- o_mg_trig  out  1  generator trigger, level, registered
- o_mg_left_or_right  out  1  0 = left fill, 1 = right fill
- o_mg_bound_index  out  9  generator bound
- i_mg_done  in  1  generator done level
- i_mg_mask  in  512  generator mask, valid while i_mg_done=1
- o_valid  out  1  result available
- i_ready  in  1  consumer accepts result
- o_mask  out  512  combined mask
- o_id  out  1  requester of current result
- o_err  out  1  result aborted by timeout; o_mask=0

## Operation
- FSM states: IDLE, R_RUN, R_REL, L_RUN, L_REL, OUT, ERR.
- IDLE:
  - if any valid, grant by round-robin pointer; pointer starts at requester 0 and is updated to "other" after every grant.
  - o_reqN_ready=1 combinationally for the granted requester only.
  - latch rcnt/lcnt/op/id → R_RUN.
- R_RUN: trig=1, left_or_right=1, bound=rcnt. On done=1, capture i_mg_mask into A → R_REL.
- R_REL: trig=0; wait done=0 → L_RUN.
- L_RUN: trig=1, left_or_right=0, bound=lcnt. On done=1, result = op ? (A | mask) : (A & mask) → L_REL.
- L_REL: trig=0; wait done=0 → OUT.
- OUT: o_valid=1, o_mask/o_id/o_err held stable; on i_ready → IDLE.
- Watchdog:
  - cycle counter runs in R_RUN/L_RUN/R_REL/L_REL and clears on state change.
  - reaching TIMEOUT → ERR: trig=0, result=0, err=1.
  - ERR waits done=0 → OUT.
- o_mg_bound_index and o_mg_left_or_right are stable from trig rise until done falls.
- Simultaneous valids: the pointer decides. A single valid is granted regardless of pointer, and the pointer still toggles to the other requester.

## Timing
- Reset: state IDLE, pointer=0, o_mg_trig=0, o_mg_left_or_right=0, o_mg_bound_index=0, o_valid=0, o_mask=0, o_id=0, o_err=0, readies 0.
- Accept in cycle T; trig high from T+1.
- With a 10-cycle generator latency (trig sampled → done):
  - done at T+11; R_REL at T+12; done low T+13.
  - L_RUN T+14; done T+24; L_REL T+25.
  - o_valid at T+27.
- Next accept is possible in the cycle after the o_valid & i_ready handshake. No overlap or pipelining.
- Reset mid-operation: all state clears immediately. trig drops asynchronously with reset; the generator shares the reset.
- o_valid never drops without i_ready.
- An i_mg_done already high on entering R_RUN is ignored. Captures require entering via IDLE/REL with done=0 observed.

## Structure
- Package mask_ctrl_pkg holds:
  - MASK_W, IDX_W, TIMEOUT
  - state enum/localparams
  - LEFT=0 / RIGHT=1 fill-direction constants
  - OP_AND / OP_OR
- Sub-module rr_arb2 (2-way round-robin, grant + pointer update on accept).
- The top instantiates rr_arb2 and contains the FSM, watchdog and result register. It does not instantiate the generator; the generator connects at the next level up.

## Test plan
- Reset: all outputs 0; req0 (rcnt=16, lcnt=500, op=AND) → o_mask = bits [15:12] set (…F000), o_id=0, o_valid at T+27.
- Both valid continuously, distinct payloads → grants alternate 0,1,0,1; o_id matches, each result correct.
- op=OR, rcnt=4, lcnt=4 → o_mask = 0xF at LSB and 0xF at MSB nibble, rest 0.
- Generator done stuck low → ERR after TIMEOUT cycles; o_valid=1, o_err=1, o_mask=0, o_mg_trig=0.
- i_ready held low 50 cycles in OUT → o_valid/o_mask/o_id stable; no new grant; readies 0.
- i_rstn asserted during L_RUN → o_mg_trig=0 and state IDLE immediately; next request completes normally.

Source files
------------

// File: rtl/mask_window_ctrl_pkg.sv
// Shared types and constants for the mask window sequencer.
// Generator width, watchdog limit, FSM states and fill/op codes.
package mask_ctrl_pkg;

    localparam int MASK_W  = 512;
    localparam int IDX_W   = 9;
    localparam int TIMEOUT = 31;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    localparam logic LEFT   = 1'b0;
    localparam logic RIGHT  = 1'b1;
    localparam logic OP_AND = 1'b0;
    localparam logic OP_OR  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_RUN,
        S_R_REL,
        S_L_RUN,
        S_L_REL,
        S_OUT,
        S_ERR
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] rcnt;
        logic [IDX_W-1:0] lcnt;
        logic             op;
        logic             id;
    } win_t;

    function automatic logic [MASK_W-1:0] mask_combine(
        input logic              op,
        input logic [MASK_W-1:0] a,
        input logic [MASK_W-1:0] b
    );
        return (op == OP_OR) ? (a | b) : (a & b);
    endfunction

endpackage

// File: rtl/mask_window_ctrl_if.sv
// Result handshake bundle: combined mask with requester id and error.
// The controller drives it as master, the consumer is the slave.
interface mask_window_ctrl_if;
    import mask_ctrl_pkg::*;

    logic              valid;
    logic              ready;
    logic [MASK_W-1:0] mask;
    logic              id;
    logic              err;

    modport master (
        output valid,
        output mask,
        output id,
        output err,
        input  ready
    );

    modport slave (
        input  valid,
        input  mask,
        input  id,
        input  err,
        output ready
    );

endinterface

// File: rtl/mask_window_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the requester
// that was not granted, so a lone requester is served immediately.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        o_gnt0 = i_en & i_valid0 & (~i_valid1 | ~ptr_q);
        o_gnt1 = i_en & i_valid1 & (~i_valid0 | ptr_q);
        ptr_d  = ptr_q;
        if (o_gnt0) begin
            ptr_d = 1'b1;
        end else if (o_gnt1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mask_window_ctrl.sv
// Runs a right-fill then a left-fill pass on the mask generator per
// request, combines the two masks and presents them with a watchdog.
module mask_window_ctrl
    import mask_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [IDX_W-1:0]  i_req0_rcnt,
    input  logic [IDX_W-1:0]  i_req0_lcnt,
    input  logic              i_req0_op,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [IDX_W-1:0]  i_req1_rcnt,
    input  logic [IDX_W-1:0]  i_req1_lcnt,
    input  logic              i_req1_op,
    output logic              o_mg_trig,
    output logic              o_mg_left_or_right,
    output logic [IDX_W-1:0]  o_mg_bound_index,
    input  logic              i_mg_done,
    input  logic [MASK_W-1:0] i_mg_mask,
    mask_window_ctrl_if.master res
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    win_t              win_q, win_d;
    logic [MASK_W-1:0] a_q, a_d;
    logic [MASK_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic              trig_q, trig_d;
    logic              lr_q, lr_d;
    logic [IDX_W-1:0]  bound_q, bound_d;

    logic gnt0, gnt1, grant, cap, tmo, watch, run_d;

    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_en     (state_q == S_IDLE),
        .i_valid0 (i_req0_valid),
        .i_valid1 (i_req1_valid),
        .o_gnt0   (gnt0),
        .o_gnt1   (gnt1)
    );

    // A done level only counts once a low level was seen in this pass.
    assign grant = gnt0 | gnt1;
    assign cap   = i_mg_done & armed_q;
    assign tmo   = (cnt_q == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant) state_d = S_R_RUN;
            S_R_RUN: if (cap) state_d = S_R_REL;
                     else if (tmo) state_d = S_ERR;
            S_R_REL: if (!i_mg_done) state_d = S_L_RUN;
                     else if (tmo) state_d = S_ERR;
            S_L_RUN: if (cap) state_d = S_L_REL;
                     else if (tmo) state_d = S_ERR;
            S_L_REL: if (!i_mg_done) state_d = S_OUT;
                     else if (tmo) state_d = S_ERR;
            S_OUT:   if (res.ready) state_d = S_IDLE;
            S_ERR:   if (!i_mg_done) state_d = S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        win_d   = win_q;
        a_d     = a_q;
        res_d   = res_q;
        err_d   = err_q;
        lr_d    = lr_q;
        bound_d = bound_q;
        if (grant) begin
            win_d.rcnt = gnt1 ? i_req1_rcnt : i_req0_rcnt;
            win_d.lcnt = gnt1 ? i_req1_lcnt : i_req0_lcnt;
            win_d.op   = gnt1 ? i_req1_op : i_req0_op;
            win_d.id   = gnt1;
            res_d      = '0;
            err_d      = 1'b0;
        end
        if (state_q == S_R_RUN && cap) begin
            a_d = i_mg_mask;
        end
        if (state_q == S_L_RUN && cap) begin
            res_d = mask_combine(win_q.op, a_q, i_mg_mask);
        end
        if (state_d == S_ERR) begin
            res_d = '0;
            err_d = 1'b1;
        end
        trig_d = (state_d == S_R_RUN) || (state_d == S_L_RUN);
        // Direction and bound hold through the release wait.
        unique case (state_d)
            S_R_RUN, S_R_REL: begin
                lr_d    = RIGHT;
                bound_d = win_d.rcnt;
            end
            S_L_RUN, S_L_REL: begin
                lr_d    = LEFT;
                bound_d = win_d.lcnt;
            end
            default: ;
        endcase
        watch = (state_q == S_R_RUN) || (state_q == S_R_REL) ||
                (state_q == S_L_RUN) || (state_q == S_L_REL);
        cnt_d = (watch && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
        run_d = (state_d == S_R_RUN) || (state_d == S_L_RUN);
        armed_d = run_d & ((state_d == state_q) ?
                           (armed_q | ~i_mg_done) : ~i_mg_done);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            win_q   <= '0;
            a_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            trig_q  <= 1'b0;
            lr_q    <= LEFT;
            bound_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            win_q   <= win_d;
            a_q     <= a_d;
            res_q   <= res_d;
            err_q   <= err_d;
            trig_q  <= trig_d;
            lr_q    <= lr_d;
            bound_q <= bound_d;
        end
    end

    assign o_req0_ready       = gnt0;
    assign o_req1_ready       = gnt1;
    assign o_mg_trig          = trig_q;
    assign o_mg_left_or_right = lr_q;
    assign o_mg_bound_index   = bound_q;
    assign res.valid          = (state_q == S_OUT);
    assign res.mask           = res_q;
    assign res.id             = win_q.id;
    assign res.err            = err_q;

endmodule

// File: tb/tb_mask_window_ctrl.sv
// Bench for mask_window_ctrl with a behavioural mask generator and
// a per-bit window reference model.
module tb_mask_window_ctrl;
    import mask_ctrl_pkg::*;

    localparam int LAT = 10;

    typedef struct packed {
        logic [8:0] r;
        logic [8:0] l;
        logic       op;
    } pay_t;

    typedef struct {
        bit           v0;
        bit           v1;
        pay_t         p0;
        pay_t         p1;
        logic [511:0] exp_mask;
        bit           exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         r0v, r1v, rdy0, rdy1;
    pay_t         q0, q1;
    logic         mg_trig, mg_lr, mg_done;
    logic [8:0]   mg_bound;
    logic [511:0] mg_mask;
    bit           gen_dead = 1'b0;
    int           gcnt;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           ptr_m = 1'b0;

    mask_window_ctrl_if rif();

    mask_window_ctrl dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_req0_valid       (r0v),
        .o_req0_ready       (rdy0),
        .i_req0_rcnt        (q0.r),
        .i_req0_lcnt        (q0.l),
        .i_req0_op          (q0.op),
        .i_req1_valid       (r1v),
        .o_req1_ready       (rdy1),
        .i_req1_rcnt        (q1.r),
        .i_req1_lcnt        (q1.l),
        .i_req1_op          (q1.op),
        .o_mg_trig          (mg_trig),
        .o_mg_left_or_right (mg_lr),
        .o_mg_bound_index   (mg_bound),
        .i_mg_done          (mg_done),
        .i_mg_mask          (mg_mask),
        .res                (rif)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] fill(input int b, input bit lr);
        logic [511:0] f;
        for (int i = 0; i < 512; i++)
            f[i] = lr ? (i < b) : (i >= 512 - b);
        return f;
    endfunction

    function automatic logic [511:0] ref_mask(input pay_t p);
        logic [511:0] m;
        int rr, ll;
        bit rb, lb;
        rr = int'(p.r);
        ll = int'(p.l);
        for (int i = 0; i < 512; i++) begin
            rb = (i < rr);
            lb = (i >= 512 - ll);
            m[i] = p.op ? (rb | lb) : (rb & lb);
        end
        return m;
    endfunction

    function automatic pay_t mk(input int r, input int l, input bit op);
        pay_t p;
        p.r = 9'(r);
        p.l = 9'(l);
        p.op = op;
        return p;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mg_done <= 1'b0;
            gcnt <= 0;
        end else if (gen_dead || !mg_trig) begin
            mg_done <= 1'b0;
            gcnt <= 0;
        end else if (!mg_done) begin
            if (gcnt == LAT - 1) mg_done <= 1'b1;
            gcnt <= gcnt + 1;
        end
    end

    always_comb begin
        mg_mask = {16{32'hDEADBEEF}};
        if (mg_done) mg_mask = fill(int'(mg_bound), mg_lr);
    end

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_txn(input bit v0, input bit v1,
                             input pay_t p0, input pay_t p1,
                             output bit gid, output int t0);
        int n;
        bit eid;
        @(posedge clk); #1;
        r0v = v0; r1v = v1; q0 = p0; q1 = p1;
        eid = (v0 && v1) ? ptr_m : v1;
        n = 0;
        @(negedge clk);
        while (!(rdy0 || rdy1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        chk("grant", {rdy1, rdy0}, eid ? 2'b10 : 2'b01);
        gid = eid;
        ptr_m = ~eid;
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
    endtask

    task automatic wait_result(output int tv);
        int n;
        n = 0;
        @(negedge clk);
        while (!rif.valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rif.valid) chk("result_wait", rif.valid, 1'b1);
        tv = cyc;
    endtask

    task automatic handshake(input int dly);
        repeat (dly) @(negedge clk);
        if (dly > 0) chk("hold_valid", rif.valid, 1'b1);
        rif.ready = 1'b1;
        @(posedge clk); #1;
        rif.ready = 1'b0;
    endtask

    task automatic run_txn(input bit v0, input bit v1,
                           input pay_t p0, input pay_t p1,
                           input int dly, output bit gid,
                           output logic [511:0] gm);
        int t0, tv;
        start_txn(v0, v1, p0, p1, gid, t0);
        wait_result(tv);
        chk("latency", tv - t0, 27);
        chk("id", rif.id, gid);
        chk("err", rif.err, 1'b0);
        chk("mask_ref", rif.mask, ref_mask(gid ? p1 : p0));
        gm = rif.mask;
        handshake(dly);
    endtask

    vec_t         vec[6];
    bit           gid, sid, ex;
    logic [511:0] gm, sm;
    int           t0, tv, n;
    pay_t         pa, pb;

    initial begin
        r0v = 0; r1v = 0; q0 = '0; q1 = '0; rif.ready = 1'b0;

        vec[0] = '{1, 0, mk(16, 500, 0), mk(0, 0, 0), 512'hF000, 0};
        vec[1] = '{0, 1, mk(0, 0, 0), mk(4, 4, 1),
                   {4'hF, 504'h0, 4'hF}, 1};
        vec[2] = '{1, 1, mk(8, 504, 0), mk(50, 50, 1), 512'h0, 0};
        vec[3] = '{1, 1, mk(7, 7, 0), mk(0, 0, 1), 512'h0, 1};
        vec[4] = '{1, 0, mk(511, 511, 0), mk(0, 0, 0),
                   {1'b0, {510{1'b1}}, 1'b0}, 0};
        vec[5] = '{0, 1, mk(0, 0, 0), mk(0, 511, 1),
                   {{511{1'b1}}, 1'b0}, 1};

        #1;
        chk("rst_trig", mg_trig, 0);
        chk("rst_valid", rif.valid, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_trig", mg_trig, 0);
        chk("idle_lr", mg_lr, 0);
        chk("idle_bound", mg_bound, 0);
        chk("idle_valid", rif.valid, 0);
        chk("idle_mask", rif.mask, 0);
        chk("idle_id", rif.id, 0);
        chk("idle_err", rif.err, 0);
        chk("idle_rdy", {rdy1, rdy0}, 0);

        foreach (vec[k]) begin
            run_txn(vec[k].v0, vec[k].v1, vec[k].p0, vec[k].p1, k % 3,
                    gid, gm);
            chk("vec_id", gid, vec[k].exp_id);
            chk("vec_mask", gm, vec[k].exp_mask);
        end

        pa = mk(20, 495, 0);
        pb = mk(300, 300, 1);
        @(posedge clk); #1;
        r0v = 1; r1v = 1; q0 = pa; q1 = pb;
        ex = ptr_m;
        for (int k = 0; k < 4; k++) begin
            wait_result(tv);
            chk("alt_id", rif.id, ex);
            chk("alt_mask", rif.mask, ref_mask(ex ? pb : pa));
            ex = ~ex;
            if (k == 3) begin
                r0v = 0; r1v = 0;
            end
            handshake(0);
        end
        ptr_m = ex;

        start_txn(1, 0, mk(100, 450, 0), '0, sid, t0);
        wait_result(tv);
        sm = rif.mask;
        chk("stall_mask", sm, ref_mask(mk(100, 450, 0)));
        r0v = 1; r1v = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("stall", {rif.valid, rif.id, rdy0, rdy1, rif.mask === sm},
                {1'b1, sid, 3'b001});
        end
        r0v = 0; r1v = 0;
        handshake(0);

        gen_dead = 1'b1;
        start_txn(1, 0, mk(33, 33, 1), '0, sid, t0);
        wait_result(tv);
        chk("tmo_window",
            (tv - t0 >= TIMEOUT) && (tv - t0 <= TIMEOUT + 3), 1);
        chk("tmo_err", rif.err, 1);
        chk("tmo_mask", rif.mask, 0);
        chk("tmo_trig", mg_trig, 0);
        chk("tmo_id", rif.id, sid);
        handshake(2);
        gen_dead = 1'b0;

        start_txn(1, 0, mk(100, 100, 1), '0, sid, t0);
        n = 0;
        @(negedge clk);
        while (!(mg_trig && !mg_lr) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_lrun", {mg_trig, mg_lr}, 2'b10);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_trig", mg_trig, 0);
        chk("mid_rst_valid", rif.valid, 0);
        chk("mid_rst_bound", {mg_lr, mg_bound}, 0);
        chk("mid_rst_err", rif.err, 0);
        @(negedge clk);
        rstn = 1'b1;
        ptr_m = 1'b0;
        run_txn(1, 1, mk(64, 480, 0), mk(9, 9, 1), 0, gid, gm);
        chk("post_rst_id", gid, 0);

        for (int k = 0; k < 20; k++) begin
            pa = mk($urandom_range(0, 511), $urandom_range(0, 511),
                    1'($urandom_range(0, 1)));
            pb = mk($urandom_range(0, 511), $urandom_range(0, 511),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                run_txn(1, 1, pa, pb, $urandom_range(0, 3), gid, gm);
            else
                run_txn(~ptr_m, ptr_m, pa, pb, $urandom_range(0, 3),
                        gid, gm);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
